// File: rtl/gcbp_pkg.sv
// Shared GCBP definitions for the BRAM array write and read paths.
package gcbp_pkg;

  localparam int unsigned C_SUBIMAGE_HEIGHT = 64;
  localparam int unsigned C_NUM_SUBIMAGES   = 16;
  localparam int unsigned C_LINE_BITS       = 128;
  localparam int unsigned C_LOC_W           = 2;
  localparam int unsigned C_ADDR_W          = 9;
  localparam int unsigned C_LINE_IDX_W      = $clog2(C_SUBIMAGE_HEIGHT);
  localparam int unsigned C_SUB_IDX_W       = $clog2(C_NUM_SUBIMAGES);

  typedef logic [C_LOC_W-1:0]      frame_loc_t;
  typedef logic [C_ADDR_W-1:0]     bram_addr_t;
  typedef logic [C_LINE_IDX_W-1:0] line_idx_t;
  typedef logic [C_SUB_IDX_W-1:0]  sub_idx_t;
  typedef logic [C_LINE_BITS-1:0]  gcbp_line_t;

  // Frame slot selects a 64-line region inside each BRAM; upper half unused.
  function automatic bram_addr_t gcbp_addr(input frame_loc_t loc, input line_idx_t line);
    return {1'b0, loc, line};
  endfunction

endpackage

// File: rtl/gcbp_bram_reader_if.sv
// Reader-side bundle: BRAM array read port plus the line-pair stream to the matcher.
interface gcbp_bram_reader_if;
  import gcbp_pkg::*;

  logic       i_start;
  frame_loc_t i_curr_frame_loc;
  frame_loc_t i_prev_frame_loc;

  logic       o_bram_array_read_en;
  bram_addr_t o_bram_array_read_addr;
  sub_idx_t   o_bram_array_read_sel;
  gcbp_line_t i_bram_array_read_data;

  gcbp_line_t o_curr_line;
  gcbp_line_t o_prev_line;
  sub_idx_t   o_subimage_idx;
  line_idx_t  o_line_idx;
  logic       o_last;
  logic       o_line_valid;
  logic       i_line_ready;

  logic       o_busy;
  logic       o_done;
  logic       o_loc_err;

  modport master (
    input  i_start, i_curr_frame_loc, i_prev_frame_loc, i_bram_array_read_data, i_line_ready,
    output o_bram_array_read_en, o_bram_array_read_addr, o_bram_array_read_sel,
           o_curr_line, o_prev_line, o_subimage_idx, o_line_idx, o_last, o_line_valid,
           o_busy, o_done, o_loc_err
  );

  modport slave (
    output i_start, i_curr_frame_loc, i_prev_frame_loc, i_bram_array_read_data, i_line_ready,
    input  o_bram_array_read_en, o_bram_array_read_addr, o_bram_array_read_sel,
           o_curr_line, o_prev_line, o_subimage_idx, o_line_idx, o_last, o_line_valid,
           o_busy, o_done, o_loc_err
  );
endinterface

// File: rtl/gcbp_rd_cnt.sv
// Line/subimage position counter for one read pass; last flags subimage 15, line 63.
module gcbp_rd_cnt
  import gcbp_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      clear_i,
  input  logic      advance_i,
  output line_idx_t line_o,
  output sub_idx_t  subimage_o,
  output logic      last_o
);

  localparam line_idx_t C_LINE_MAX = C_LINE_IDX_W'(C_SUBIMAGE_HEIGHT - 1);
  localparam sub_idx_t  C_SUB_MAX  = C_SUB_IDX_W'(C_NUM_SUBIMAGES - 1);

  line_idx_t line_q, line_d;
  sub_idx_t  sub_q, sub_d;
  logic      last_q, last_d;

  always_comb begin
    line_d = line_q;
    sub_d  = sub_q;
    if (clear_i) begin
      line_d = '0;
      sub_d  = '0;
    end else if (advance_i) begin
      if (line_q == C_LINE_MAX) begin
        line_d = '0;
        sub_d  = sub_q + C_SUB_IDX_W'(1);
      end else begin
        line_d = line_q + C_LINE_IDX_W'(1);
      end
    end
    last_d = (line_d == C_LINE_MAX) && (sub_d == C_SUB_MAX);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      line_q <= '0;
      sub_q  <= '0;
      last_q <= 1'b0;
    end else begin
      line_q <= line_d;
      sub_q  <= sub_d;
      last_q <= last_d;
    end
  end

  assign line_o     = line_q;
  assign subimage_o = sub_q;
  assign last_o     = last_q;

endmodule

// File: rtl/gcbp_bram_reader.sv
// Streams curr/prev frame line pairs for all 16 subimages out of the shared BRAM array.
module gcbp_bram_reader
  import gcbp_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  gcbp_bram_reader_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_CURR = 3'd1,
    S_RD_PREV = 3'd2,
    S_CAPTURE = 3'd3,
    S_OUT     = 3'd4
  } state_e;

  state_e     state_q, state_d;
  frame_loc_t curr_loc_q, prev_loc_q;
  gcbp_line_t curr_line_q, prev_line_q;
  logic       done_q, loc_err_q;

  line_idx_t  line_idx;
  sub_idx_t   sub_idx;
  logic       cnt_last;

  logic       start_ok_c;
  logic       start_bad_c;
  logic       xfer_c;

  assign start_ok_c  = (state_q == S_IDLE) && bus.i_start &&
                       (bus.i_curr_frame_loc != bus.i_prev_frame_loc);
  assign start_bad_c = (state_q == S_IDLE) && bus.i_start &&
                       (bus.i_curr_frame_loc == bus.i_prev_frame_loc);
  assign xfer_c      = (state_q == S_OUT) && bus.i_line_ready;

  gcbp_rd_cnt u_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .clear_i    (start_ok_c),
    .advance_i  (xfer_c),
    .line_o     (line_idx),
    .subimage_o (sub_idx),
    .last_o     (cnt_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ok_c) state_d = S_RD_CURR;
      S_RD_CURR: state_d = S_RD_PREV;
      S_RD_PREV: state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_OUT;
      S_OUT:     if (xfer_c) state_d = cnt_last ? S_IDLE : S_RD_CURR;
      default:   state_d = S_IDLE;
    endcase
  end

  // BRAM read strobe/address decode straight from state and position.
  always_comb begin
    bus.o_bram_array_read_en   = 1'b0;
    bus.o_bram_array_read_addr = '0;
    bus.o_bram_array_read_sel  = '0;
    bus.o_line_valid           = 1'b0;
    bus.o_busy                 = (state_q != S_IDLE);
    case (state_q)
      S_RD_CURR: begin
        bus.o_bram_array_read_en   = 1'b1;
        bus.o_bram_array_read_addr = gcbp_addr(curr_loc_q, line_idx);
        bus.o_bram_array_read_sel  = sub_idx;
      end
      S_RD_PREV: begin
        bus.o_bram_array_read_en   = 1'b1;
        bus.o_bram_array_read_addr = gcbp_addr(prev_loc_q, line_idx);
        bus.o_bram_array_read_sel  = sub_idx;
      end
      S_OUT:   bus.o_line_valid = 1'b1;
      default: ;
    endcase
  end

  // Data for a read lands one cycle later, so each holding register loads in the following state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      curr_loc_q  <= '0;
      prev_loc_q  <= '0;
      curr_line_q <= '0;
      prev_line_q <= '0;
      done_q      <= 1'b0;
      loc_err_q   <= 1'b0;
    end else begin
      if (start_ok_c) begin
        curr_loc_q <= bus.i_curr_frame_loc;
        prev_loc_q <= bus.i_prev_frame_loc;
      end
      if (state_q == S_RD_PREV) curr_line_q <= bus.i_bram_array_read_data;
      if (state_q == S_CAPTURE) prev_line_q <= bus.i_bram_array_read_data;
      done_q    <= xfer_c && cnt_last;
      loc_err_q <= start_bad_c;
    end
  end

  assign bus.o_curr_line    = curr_line_q;
  assign bus.o_prev_line    = prev_line_q;
  assign bus.o_subimage_idx = sub_idx;
  assign bus.o_line_idx     = line_idx;
  assign bus.o_last         = cnt_last;
  assign bus.o_done         = done_q;
  assign bus.o_loc_err      = loc_err_q;

endmodule

// File: tb/tb_gcbp_bram_reader.sv
// Scoreboard bench for gcbp_bram_reader: expected beats queued at start, popped by a monitor.
module tb_gcbp_bram_reader;
  import gcbp_pkg::*;

  typedef struct {
    logic [127:0] curr;
    logic [127:0] prev;
    logic [3:0]   sub;
    logic [5:0]   line;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gcbp_bram_reader_if bus();

  gcbp_bram_reader dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    beats_seen = 0;
  logic  expect_done = 1'b0;
  logic  wrap_pending = 1'b0;

  // Each 16-bit lane carries {sel, addr, lane}, so any wrong sel/addr shows in the data.
  function automatic logic [127:0] bram_word(input logic [3:0] sel, input logic [8:0] addr);
    logic [127:0] w;
    for (int i = 0; i < 8; i++) w[i*16 +: 16] = {sel, addr, 3'(i)};
    return w;
  endfunction

  always @(posedge clk) begin
    if (bus.o_bram_array_read_en)
      bus.i_bram_array_read_data <= bram_word(bus.o_bram_array_read_sel, bus.o_bram_array_read_addr);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer monitor: pops the scoreboard on every valid&ready, tracks done and the line wrap.
  always @(negedge clk) begin
    beat_t e;
    if (wrap_pending) begin
      check("wrap_read_en", 128'(bus.o_bram_array_read_en), 128'(1));
      check("wrap_read_line", 128'(bus.o_bram_array_read_addr[5:0]), 128'(0));
      check("wrap_read_sel", 128'(bus.o_bram_array_read_sel), 128'(1));
      wrap_pending = 1'b0;
    end
    if (expect_done) begin
      check("done_pulse", 128'(bus.o_done), 128'(1));
      check("busy_after_last", 128'(bus.o_busy), 128'(0));
      expect_done = 1'b0;
    end else if (bus.o_done) begin
      check("spurious_done", 128'(bus.o_done), 128'(0));
    end
    if (bus.o_line_valid && bus.i_line_ready) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        check("extra_beat_valid", 128'(bus.o_line_valid), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("beat_curr", bus.o_curr_line, e.curr);
        check("beat_prev", bus.o_prev_line, e.prev);
        check("beat_sub", 128'(bus.o_subimage_idx), 128'(e.sub));
        check("beat_line", 128'(bus.o_line_idx), 128'(e.line));
        check("beat_last", 128'(bus.o_last), 128'(e.last));
        if (e.last) expect_done = 1'b1;
        if (e.sub == 4'd0 && e.line == 6'd63) wrap_pending = 1'b1;
      end
    end
  end

  task automatic push_pass(input logic [1:0] c, input logic [1:0] p);
    beat_t b;
    for (int s = 0; s < 16; s++) begin
      for (int l = 0; l < 64; l++) begin
        b.sub  = 4'(s);
        b.line = 6'(l);
        b.curr = bram_word(4'(s), {1'b0, c, 6'(l)});
        b.prev = bram_word(4'(s), {1'b0, p, 6'(l)});
        b.last = (s == 15) && (l == 63);
        exp_q.push_back(b);
      end
    end
  endtask

  // Returns during the first cycle after the accepting edge.
  task automatic start_pass(input logic [1:0] c, input logic [1:0] p);
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    bus.i_curr_frame_loc = c;
    bus.i_prev_frame_loc = p;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_curr_frame_loc = ~c;
    bus.i_prev_frame_loc = c;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (bus.o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 128'(bus.o_busy), 128'(0));
    @(negedge clk);
    check({name, "_beats_left"}, 128'(exp_q.size()), 128'(0));
    check({name, "_done_missing"}, 128'(expect_done), 128'(0));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, 128'(bus.o_line_valid), 128'(0));
    check({name, "_busy"}, 128'(bus.o_busy), 128'(0));
    check({name, "_done"}, 128'(bus.o_done), 128'(0));
    check({name, "_loc_err"}, 128'(bus.o_loc_err), 128'(0));
    check({name, "_read_en"}, 128'(bus.o_bram_array_read_en), 128'(0));
    check({name, "_addr"}, 128'(bus.o_bram_array_read_addr), 128'(0));
    check({name, "_sel"}, 128'(bus.o_bram_array_read_sel), 128'(0));
    check({name, "_curr"}, bus.o_curr_line, 128'(0));
    check({name, "_prev"}, bus.o_prev_line, 128'(0));
    check({name, "_sub"}, 128'(bus.o_subimage_idx), 128'(0));
    check({name, "_line"}, 128'(bus.o_line_idx), 128'(0));
    check({name, "_last"}, 128'(bus.o_last), 128'(0));
  endtask

  initial begin
    logic [127:0] snap_curr, snap_prev;
    logic [3:0]   snap_sub;
    logic [5:0]   snap_line;
    logic         snap_last;
    int           n;
    int           base;

    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_curr_frame_loc = '0;
    bus.i_prev_frame_loc = '0;
    bus.i_line_ready = 1'b1;
    bus.i_bram_array_read_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Pass A: curr=1 prev=0, address sequence and first-beat latency.
    push_pass(2'd1, 2'd0);
    start_pass(2'd1, 2'd0);
    @(negedge clk);
    check("a_k1_read_en", 128'(bus.o_bram_array_read_en), 128'(1));
    check("a_k1_addr", 128'(bus.o_bram_array_read_addr), 128'h040);
    check("a_k1_sel", 128'(bus.o_bram_array_read_sel), 128'(0));
    check("a_k1_valid", 128'(bus.o_line_valid), 128'(0));
    check("a_k1_busy", 128'(bus.o_busy), 128'(1));
    @(negedge clk);
    check("a_k2_read_en", 128'(bus.o_bram_array_read_en), 128'(1));
    check("a_k2_addr", 128'(bus.o_bram_array_read_addr), 128'h000);
    check("a_k2_valid", 128'(bus.o_line_valid), 128'(0));
    @(negedge clk);
    check("a_k3_read_en", 128'(bus.o_bram_array_read_en), 128'(0));
    check("a_k3_valid", 128'(bus.o_line_valid), 128'(0));
    @(negedge clk);
    check("a_k4_valid", 128'(bus.o_line_valid), 128'(1));
    wait_idle("pass_a", 5000);

    // Equal locations are rejected with a single error pulse.
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    bus.i_curr_frame_loc = 2'd2;
    bus.i_prev_frame_loc = 2'd2;
    @(posedge clk); #1 bus.i_start = 1'b0;
    @(negedge clk);
    check("locerr_pulse", 128'(bus.o_loc_err), 128'(1));
    check("locerr_busy", 128'(bus.o_busy), 128'(0));
    check("locerr_read_en", 128'(bus.o_bram_array_read_en), 128'(0));
    @(negedge clk);
    check("locerr_clear", 128'(bus.o_loc_err), 128'(0));
    check("locerr_busy2", 128'(bus.o_busy), 128'(0));
    check("locerr_read_en2", 128'(bus.o_bram_array_read_en), 128'(0));

    // Pass B: start while busy is ignored, then a 10-cycle stall on (3,17).
    push_pass(2'd3, 2'd1);
    start_pass(2'd3, 2'd1);
    repeat (100) @(posedge clk);
    #1;
    bus.i_start = 1'b1;
    bus.i_curr_frame_loc = 2'd0;
    bus.i_prev_frame_loc = 2'd2;
    @(posedge clk); #1 bus.i_start = 1'b0;
    @(negedge clk);
    check("busy_start_busy", 128'(bus.o_busy), 128'(1));
    check("busy_start_locerr", 128'(bus.o_loc_err), 128'(0));
    n = 0;
    while (!(bus.o_busy && !bus.o_line_valid && !bus.o_bram_array_read_en &&
             bus.o_subimage_idx == 4'd3 && bus.o_line_idx == 6'd17) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("stall_found_timeout", 128'(n < 5000), 128'(1));
    @(posedge clk); #1 bus.i_line_ready = 1'b0;
    @(negedge clk);
    snap_curr = bus.o_curr_line;
    snap_prev = bus.o_prev_line;
    snap_sub  = bus.o_subimage_idx;
    snap_line = bus.o_line_idx;
    snap_last = bus.o_last;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_valid", 128'(bus.o_line_valid), 128'(1));
      check("stall_read_en", 128'(bus.o_bram_array_read_en), 128'(0));
      check("stall_curr", bus.o_curr_line, snap_curr);
      check("stall_prev", bus.o_prev_line, snap_prev);
      check("stall_sub", 128'(bus.o_subimage_idx), 128'(snap_sub));
      check("stall_line", 128'(bus.o_line_idx), 128'(snap_line));
      check("stall_last", 128'(bus.o_last), 128'(snap_last));
    end
    @(posedge clk); #1 bus.i_line_ready = 1'b1;
    wait_idle("pass_b", 5000);

    // Pass C: reset after beat 500 aborts with no done.
    push_pass(2'd0, 2'd3);
    base = beats_seen;
    start_pass(2'd0, 2'd3);
    n = 0;
    while (beats_seen < base + 500 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_timeout", 128'(beats_seen - base), 128'(500));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("abort");
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_busy", 128'(bus.o_busy), 128'(0));

    // Pass D: restart from subimage 0, line 0 with new locations.
    push_pass(2'd2, 2'd0);
    start_pass(2'd2, 2'd0);
    @(negedge clk);
    check("d_k1_addr", 128'(bus.o_bram_array_read_addr), 128'h080);
    check("d_k1_sel", 128'(bus.o_bram_array_read_sel), 128'(0));
    check("d_k1_line", 128'(bus.o_line_idx), 128'(0));
    wait_idle("pass_d", 5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
